// File: rtl/axi_slave_mem.sv
// axi_slave_mem -- simplified AXI-style byte memory slave with independent
// read and write burst engines sharing one byte-wide memory array.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   ARVALID, AR[15:0]            read request {ARADDR[15:8], ARLEN[7:4], ARID[3:0]}
//   ARREADY                      one-cycle accept pulse for the read request
//   RVALID, RREADY, RLAST        read beat handshake and last-beat flag
//   ROUT[8:0]                    {RDATA[8:1], RRESP[0]} (RRESP=1 on wrapped beats)
//   RIDLE                        read engine idle
//   AWVALID, AW[11:0]            write request {AWADDR[11:4], AWID[3:0]}
//   AWREADY                      one-cycle accept pulse for the write request
//   WVALID, WDATA[7:0], WLAST    write beat
//   WREADY                       write beats accepted while high
//   BVALID, BREADY, BRESP[4:0]   write response {BID[4:1], BERR[0]}
//   WIDLE                        write engine idle
module axi_slave_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ARVALID,
  input  logic [15:0] AR,
  output logic        ARREADY,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [8:0]  ROUT,
  output logic        RLAST,
  output logic        RIDLE,
  input  logic        AWVALID,
  input  logic [11:0] AW,
  output logic        AWREADY,
  input  logic        WVALID,
  input  logic [7:0]  WDATA,
  input  logic        WLAST,
  output logic        WREADY,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [4:0]  BRESP,
  output logic        WIDLE
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_DATA, W_RESP} w_state_t;

  logic [7:0] r_mem [MEM_DEPTH];

  // ---------------- read engine ----------------
  r_state_t   r_rstate, w_rstate_next;
  logic [7:0] r_raddr;
  logic [3:0] r_rlen;
  logic [3:0] r_rid;
  logic [3:0] r_beat;
  logic       r_rwrap;   // sticky: burst address has passed 0xFF -> 0x00
  logic       w_rlast;

  assign w_rlast = (r_beat == r_rlen);

  // The R channel carries no ID field, so the captured read ID is not driven out.
  logic w_unused;
  assign w_unused = ^r_rid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_next;
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    w_rstate_next = r_rstate;
    ARREADY       = 1'b0;
    RVALID        = 1'b0;
    RLAST         = 1'b0;
    ROUT          = 9'd0;
    RIDLE         = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        RIDLE = 1'b1;
        if (ARVALID) w_rstate_next = R_ACCEPT;
      end
      R_ACCEPT: begin
        ARREADY       = 1'b1;
        w_rstate_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = w_rlast;
        // Asynchronous array read: a write committing this edge shows up next cycle.
        ROUT   = {r_mem[r_raddr], r_rwrap};
        if (RREADY && w_rlast) w_rstate_next = R_IDLE;
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr <= 8'd0;
      r_rlen  <= 4'd0;
      r_rid   <= 4'd0;
      r_beat  <= 4'd0;
      r_rwrap <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: if (ARVALID) begin
          r_raddr <= AR[15:8];
          r_rlen  <= AR[7:4];
          r_rid   <= AR[3:0];
        end
        R_ACCEPT: begin
          r_beat  <= 4'd0;
          r_rwrap <= 1'b0;
        end
        R_DATA: if (RREADY && !w_rlast) begin
          r_raddr <= r_raddr + 8'd1;
          r_beat  <= r_beat + 4'd1;
          if (r_raddr == 8'hFF) r_rwrap <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- write engine ----------------
  w_state_t         r_wstate, w_wstate_next;
  logic [7:0]       r_waddr;
  logic [3:0]       r_wid;
  logic [CNT_W-1:0] r_wcnt;    // beats written so far, saturates at MAX_BEATS
  logic             r_werr;
  logic             w_wfire;
  logic             w_wen;

  assign w_wfire = (r_wstate == W_DATA) && WVALID;
  assign w_wen   = w_wfire && (r_wcnt < MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_next;
  end

  always_comb begin
    w_wstate_next = r_wstate;
    AWREADY       = 1'b0;
    WREADY        = 1'b0;
    BVALID        = 1'b0;
    BRESP         = 5'd0;
    WIDLE         = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        WIDLE = 1'b1;
        if (AWVALID) w_wstate_next = W_ACCEPT;
      end
      W_ACCEPT: begin
        AWREADY       = 1'b1;
        w_wstate_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && WLAST) w_wstate_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BRESP  = {r_wid, r_werr};
        if (BREADY) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waddr <= 8'd0;
      r_wid   <= 4'd0;
      r_wcnt  <= '0;
      r_werr  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (AWVALID) begin
          r_waddr <= AW[11:4];
          r_wid   <= AW[3:0];
        end
        W_ACCEPT: begin
          r_wcnt <= '0;
          r_werr <= 1'b0;
        end
        W_DATA: if (w_wfire) begin
          r_waddr <= r_waddr + 8'd1;
          if (w_wen) r_wcnt <= r_wcnt + 1'b1;
          else       r_werr <= 1'b1;
          // A further beat after 0xFF lands on 0x00: flag the wrap.
          if (r_waddr == 8'hFF && !WLAST) r_werr <= 1'b1;
        end
        W_RESP: if (BREADY) r_werr <= 1'b0;
        default: ;
      endcase
    end
  end

  // NOTE: the memory array has no reset; contents survive rst, and w_wen is
  // already forced low during rst because the write FSM resets to W_IDLE.
  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_waddr] <= WDATA;
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
module tb_axi_slave_mem;
  localparam int MAX_BEATS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST, RIDLE;
  logic [15:0] AR;
  logic [8:0]  ROUT;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY, WIDLE;
  logic [11:0] AW;
  logic [7:0]  WDATA;
  logic [4:0]  BRESP;

  axi_slave_mem #(.MEM_DEPTH(256), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .AR(AR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .ROUT(ROUT), .RLAST(RLAST), .RIDLE(RIDLE),
    .AWVALID(AWVALID), .AW(AW), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WLAST(WLAST), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .WIDLE(WIDLE)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference memory and expected read-beat scoreboard.
  logic [7:0] model [256];
  typedef struct {
    logic [7:0] data;
    logic       resp;
    logic       last;
  } beat_t;
  beat_t exp_q[$];

  // Write burst of n beats with data base, base+1, ...; BREADY held low for bstall cycles.
  task automatic do_write(input logic [7:0] addr, input logic [3:0] id, input int n,
                          input logic [7:0] base, input int bstall);
    logic       exp_err;
    logic [7:0] a;
    exp_err = 1'b0;
    @(negedge clk); AWVALID = 1'b1; AW = {addr, id};
    @(negedge clk); AWVALID = 1'b0;
    tests_run++; if (AWREADY !== 1'b1) begin tests_failed++; $display("FAIL awready_pulse: got %b want 1", AWREADY); end
    @(negedge clk);
    tests_run++; if ({AWREADY, WREADY} !== 2'b01) begin tests_failed++; $display("FAIL awready_drop_wready: got %b want 01", {AWREADY, WREADY}); end
    for (int i = 0; i < n; i++) begin
      a      = 8'(addr + i);
      WVALID = 1'b1;
      WDATA  = 8'(base + i);
      WLAST  = (i == n - 1);
      if (i < MAX_BEATS) model[a] = WDATA;
      else               exp_err = 1'b1;
      if (i > 0 && a == 8'h00) exp_err = 1'b1;
      @(negedge clk);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    tests_run++; if ({WREADY, BVALID, BRESP} !== {1'b0, 1'b1, id, exp_err}) begin
      tests_failed++; $display("FAIL bresp: got wready=%b bvalid=%b bresp=%b want 0 1 %b", WREADY, BVALID, BRESP, {id, exp_err});
    end
    for (int k = 0; k < bstall; k++) begin
      @(negedge clk);
      tests_run++; if ({BVALID, BRESP} !== {1'b1, id, exp_err}) begin
        tests_failed++; $display("FAIL bresp_hold: cycle %0d got %b want %b", k, {BVALID, BRESP}, {1'b1, id, exp_err});
      end
    end
    BREADY = 1'b1;
    @(negedge clk); BREADY = 1'b0;
    tests_run++; if ({BVALID, BRESP, WIDLE} !== 7'b0_00000_1) begin
      tests_failed++; $display("FAIL b_release: got %b want 0000001", {BVALID, BRESP, WIDLE});
    end
  endtask

  // Read burst; RREADY follows pat[k] for cycle k < pat_len, then stays 1.
  task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input logic [7:0] pat, input int pat_len);
    beat_t b;
    int    k;
    @(negedge clk); ARVALID = 1'b1; AR = {addr, len, id};
    @(negedge clk); ARVALID = 1'b0;
    tests_run++; if (ARREADY !== 1'b1) begin tests_failed++; $display("FAIL arready_pulse: got %b want 1", ARREADY); end
    for (int i = 0; i <= int'(len); i++) begin
      b.data = model[8'(addr + i)];
      b.resp = (int'(addr) + i) > 255;
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
    @(negedge clk);
    tests_run++; if (ARREADY !== 1'b0) begin tests_failed++; $display("FAIL arready_drop: got %b want 0", ARREADY); end
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      b = exp_q[0];
      tests_run++; if ({RVALID, RLAST, ROUT} !== {1'b1, b.last, b.data, b.resp}) begin
        tests_failed++; $display("FAIL r_beat: cycle %0d got valid=%b last=%b rout=%h want 1 %b %h",
                                 k, RVALID, RLAST, ROUT, b.last, {b.data, b.resp});
      end
      RREADY = (k < pat_len) ? pat[k] : 1'b1;
      if (RREADY) void'(exp_q.pop_front());
      @(negedge clk);
      k++;
    end
    RREADY = 1'b0;
    tests_run++; if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL r_timeout: %0d beats outstanding", exp_q.size()); exp_q.delete();
    end
    tests_run++; if ({RVALID, RLAST, RIDLE} !== 3'b001) begin
      tests_failed++; $display("FAIL r_end: got %b want 001", {RVALID, RLAST, RIDLE});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if ({ARREADY, RVALID, RLAST, AWREADY, WREADY, BVALID, ROUT, BRESP, RIDLE, WIDLE} !== {20'd0, 2'b11}) begin
      tests_failed++; $display("FAIL reset_outputs: got %b want all 0 with idles 1",
                               {ARREADY, RVALID, RLAST, AWREADY, WREADY, BVALID, ROUT, BRESP, RIDLE, WIDLE});
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if ({RIDLE, WIDLE, RVALID, BVALID} !== 4'b1100) begin
      tests_failed++; $display("FAIL post_reset_idle: got %b want 1100", {RIDLE, WIDLE, RVALID, BVALID});
    end
  endtask

  task automatic test_write_basic();
    do_write(8'h10, 4'd3, 3, 8'hA1, 0);
  endtask

  task automatic test_read_basic();
    do_read(8'h10, 4'd2, 4'd3, 8'hFF, 0);
  endtask

  task automatic test_wrap();
    do_write(8'hFE, 4'd6, 3, 8'hC0, 0);  // 0xFE,0xFF,0x00 -> err set
    do_read(8'hFF, 4'd1, 4'd6, 8'hFF, 0);
  endtask

  task automatic test_overflow();
    do_write(8'h50, 4'd1, 1, 8'h77, 0);
    do_write(8'h40, 4'd2, 18, 8'h00, 3);
    do_read(8'h4E, 4'd2, 4'd2, 8'hFF, 0);  // 0x50 must still hold 0x77
  endtask

  task automatic test_stall();
    do_read(8'h10, 4'd2, 4'd3, 8'b0000_1001, 4);
  endtask

  task automatic test_rw_same_addr();
    @(negedge clk); ARVALID = 1'b1; AR = {8'h11, 4'd0, 4'd1};
    @(negedge clk); ARVALID = 1'b0;
    @(negedge clk);
    @(negedge clk); AWVALID = 1'b1; AW = {8'h11, 4'd2};
    @(negedge clk); AWVALID = 1'b0;
    @(negedge clk); WVALID = 1'b1; WDATA = 8'h5C; WLAST = 1'b1;
    tests_run++; if (ROUT !== {model[8'h11], 1'b0}) begin
      tests_failed++; $display("FAIL rw_old_byte: got %h want %h", ROUT, {model[8'h11], 1'b0});
    end
    @(negedge clk); WVALID = 1'b0; WLAST = 1'b0;
    model[8'h11] = 8'h5C;
    tests_run++; if (ROUT !== {8'h5C, 1'b0}) begin
      tests_failed++; $display("FAIL rw_new_byte: got %h want %h", ROUT, {8'h5C, 1'b0});
    end
    BREADY = 1'b1;
    @(negedge clk); BREADY = 1'b0; RREADY = 1'b1;
    @(negedge clk); RREADY = 1'b0;
    tests_run++; if ({RIDLE, WIDLE} !== 2'b11) begin
      tests_failed++; $display("FAIL rw_idle: got %b want 11", {RIDLE, WIDLE});
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk); ARVALID = 1'b1; AR = {8'h00, 4'd15, 4'd4};
    @(negedge clk); ARVALID = 1'b0; AWVALID = 1'b1; AW = {8'h80, 4'd5};
    @(negedge clk); AWVALID = 1'b0;
    @(negedge clk); WVALID = 1'b1; WDATA = 8'hE1; WLAST = 1'b0; model[8'h80] = 8'hE1;
    @(negedge clk); WDATA = 8'hE2; model[8'h81] = 8'hE2;
    @(negedge clk); WDATA = 8'hE3;
    rst = 1'b1;
    #1;
    tests_run++; if ({ARREADY, RVALID, RLAST, AWREADY, WREADY, BVALID, ROUT, BRESP, RIDLE, WIDLE} !== {20'd0, 2'b11}) begin
      tests_failed++; $display("FAIL reset_abort: got %b want all 0 with idles 1",
                               {ARREADY, RVALID, RLAST, AWREADY, WREADY, BVALID, ROUT, BRESP, RIDLE, WIDLE});
    end
    @(negedge clk); WVALID = 1'b0; WDATA = 8'h00; rst = 1'b0;
    do_write(8'h90, 4'd7, 1, 8'h33, 0);
    do_read(8'h80, 4'd1, 4'd5, 8'hFF, 0);
  endtask

  initial begin
    rst = 1'b1;
    ARVALID = 1'b0; AR = '0; RREADY = 1'b0;
    AWVALID = 1'b0; AW = '0; WVALID = 1'b0; WDATA = '0; WLAST = 1'b0; BREADY = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_overflow();
    test_stall();
    test_rw_same_addr();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, giving the number of byte locations, addressed by 8 bits.
REQ-002 SHALL have parameter MAX_BEATS, default 16, giving the largest burst length in beats.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ARVALID  input  1  read-address valid from the master.
REQ-007 AR  input  16  {ARADDR[15:8], ARLEN[7:4], ARID[3:0]}; burst beats = ARLEN+1.
REQ-008 ARREADY  output  1  read address accepted; one-cycle pulse.
REQ-009 RVALID  output  1  read beat valid.
REQ-010 RREADY  input  1  master accepts the read beat.
REQ-011 ROUT  output  9  {RDATA[8:1], RRESP[0]}.
REQ-012 RLAST  output  1  final read beat.
REQ-013 RIDLE  output  1  read FSM in R_IDLE.
REQ-014 AWVALID  input  1  write-address valid.
REQ-015 AW  input  12  {AWADDR[11:4], AWID[3:0]}.
REQ-016 AWREADY  output  1  write address accepted; one-cycle pulse.
REQ-017 WVALID / WDATA / WLAST  input  1/8/1  write beat, byte data, and last-beat flag.
REQ-018 WREADY  output  1  slave accepts write beats.
REQ-019 BVALID  output  1  write response valid.
REQ-020 BREADY  input  1  master accepts the response.
REQ-021 BRESP  output  5  {BID[4:1], BERR[0]}.
REQ-022 WIDLE  output  1  write FSM in W_IDLE.

Function
REQ-023 Read FSM states SHALL be R_IDLE -> R_ACCEPT -> R_DATA -> R_IDLE; write FSM states SHALL be W_IDLE -> W_ACCEPT -> W_DATA -> W_RESP -> W_IDLE.
REQ-024 The read and write FSMs SHALL be independent and SHALL operate concurrently.
REQ-025 In R_IDLE, when ARVALID is sampled high, the FSM SHALL latch addr, len and id and enter R_ACCEPT.
REQ-026 ARREADY SHALL be 1 only in R_ACCEPT, for exactly one cycle; the FSM SHALL then enter R_DATA.
REQ-027 In R_DATA, RVALID SHALL be 1 and ROUT[8:1] SHALL equal mem[raddr] combinationally.
REQ-028 On each RVALID&&RREADY, raddr SHALL increment modulo 256 and the beat count SHALL increment.
REQ-029 While RREADY=0, the current beat SHALL be held unchanged.
REQ-030 RLAST SHALL be 1 exactly on beat ARLEN; after the handshake on that beat, RVALID and RLAST SHALL go to 0 and the FSM SHALL enter R_IDLE.
REQ-031 RRESP SHALL be 0, except 1 on beats whose address wrapped past 0xFF to 0x00 within the burst; the wrapped data SHALL still be returned.
REQ-032 ARVALID SHALL be ignored outside R_IDLE.
REQ-033 In W_IDLE, when AWVALID is sampled high, the FSM SHALL latch waddr and id and enter W_ACCEPT, with AWREADY=1 for one cycle, then enter W_DATA.
REQ-034 In W_DATA, WREADY SHALL be 1.
REQ-035 On each WVALID&&WREADY, mem[waddr] SHALL be written with WDATA and waddr SHALL increment modulo 256.
REQ-036 Beats beyond MAX_BEATS SHALL be accepted but not written, and SHALL set err.
REQ-037 An address wrap during a write burst SHALL set err, and the wrapped byte SHALL still be written.
REQ-038 On the accepted beat with WLAST=1, the FSM SHALL drop WREADY and enter W_RESP with BVALID=1 and BRESP={id, err}.
REQ-039 BVALID and BRESP SHALL be held until BREADY; on BREADY the FSM SHALL go to W_IDLE and clear BVALID, BRESP and err.
REQ-040 A write committed at edge t SHALL be visible on ROUT from the cycle after t.
REQ-041 When a read and a write target the same address in the same cycle, the read SHALL return the old byte.
REQ-042 AWVALID, and WVALID outside W_DATA, SHALL be ignored; no memory write SHALL occur outside W_DATA.

Reset
REQ-043 On rst, both FSMs SHALL go to idle immediately, aborting any burst in progress.
REQ-044 During rst, ARREADY, RVALID, RLAST, AWREADY, WREADY and BVALID SHALL be 0, and ROUT and BRESP SHALL be 0.
REQ-045 During rst, RIDLE and WIDLE SHALL be 1.
REQ-046 Reset SHALL NOT clear memory contents; an aborted write keeps the beats already written.

Verification
REQ-047 Write AW=0x10/id 3, beats 0xA1,0xA2,0xA3 (WLAST on third) -> AWREADY one-cycle pulse; mem[0x10..0x12]=A1,A2,A3; BRESP=5'b0011_0.
REQ-048 Read AR={0x10,len 2,id 3} with RREADY=1 -> ARREADY pulse; ROUT[8:1]=A1,A2,A3 on consecutive cycles; RLAST on third; RRESP=0.
REQ-049 Read at 0xFF, len 1 -> beat 0 addr 0xFF RRESP=0; beat 1 addr 0x00 RRESP=1; RLAST on beat 1.
REQ-050 Write 18 beats at 0x40 -> only 0x40..0x4F written; mem[0x50] unchanged; BRESP[0]=1; BVALID held 3 cycles with BREADY=0 until BREADY=1.
REQ-051 Read RREADY toggling 1,0,0,1 -> beat held stable during the stall cycles; no beat skipped or duplicated.
REQ-052 Assert rst mid write burst after 2 beats -> all outputs 0 and RIDLE/WIDLE=1 immediately; the 2 bytes remain in memory; a new AW is accepted after rst deasserts.
